// File: rtl/timing_gen_pkg.sv
// timing_gen_pkg
//   Shared constants for the video timing generator: counter width, the
//   saturation value used as the "not yet synchronised" marker, and a
//   saturating increment helper.
package timing_gen_pkg;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      return (val == CNT_SAT) ? val : val + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Registers a sync input once and flags its rising edge. A level held
//   high produces exactly one rise pulse.
// Ports:
//   clk  in   clock (rising edge)
//   rst  in   asynchronous active-high reset, clears the history register
//   sig  in   sync level, synchronous to clk
//   rise out  sig & ~registered sig (combinational)
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig;
      end
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/timing_gen.sv
// timing_gen
//   Recovers frame-valid / line-valid from incoming hsync/vsync. Pixel and
//   line counters restart on sync rising edges and saturate, so outputs stay
//   inactive until the first vsync and beyond the active window.
//   Optional build macro TIMING_GEN_LOCK_EN: gates outputs with a lock flag
//   that needs two consecutive vsync rises exactly one full frame of hsync
//   rises apart; any mismatch or reset drops the lock.
// Ports:
//   pix_clk  in   pixel clock, all logic on rising edge
//   pix_rst  in   asynchronous active-high reset
//   vsync_i  in   vertical sync, active-high
//   hsync_i  in   horizontal sync, active-high
//   fv_o     out  frame valid, registered
//   lv_o     out  line valid, registered
module timing_gen
   import timing_gen_pkg::*;
#(
   parameter int H_ACTIVE      = 1280,
   parameter int H_SYNC        = 40,
   parameter int H_BACK_PORCH  = 220,
   parameter int H_FRONT_PORCH = 110,
   parameter int V_ACTIVE      = 720,
   parameter int V_SYNC        = 5,
   parameter int V_BACK_PORCH  = 20,
   parameter int V_FRONT_PORCH = 5
) (
   input  logic pix_clk,
   input  logic pix_rst,
   input  logic vsync_i,
   input  logic hsync_i,
   output logic fv_o,
   output logic lv_o
);

   localparam int H_TOTAL = H_SYNC + H_BACK_PORCH + H_ACTIVE + H_FRONT_PORCH;
   localparam int V_TOTAL = V_SYNC + V_BACK_PORCH + V_ACTIVE + V_FRONT_PORCH;

   localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BACK_PORCH);
   localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BACK_PORCH + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BACK_PORCH);
   localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BACK_PORCH + V_ACTIVE);

   // The saturated value marks "no sync seen", so a real frame must fit below it.
   if (H_TOTAL >= int'(CNT_SAT) || V_TOTAL >= int'(CNT_SAT)) begin : g_bad_size
      $error("timing_gen: line or frame total does not fit the counters");
   end

   logic hs_rise;
   logic vs_rise;

   sync_edge_det u_hs_det (
      .clk  (pix_clk),
      .rst  (pix_rst),
      .sig  (hsync_i),
      .rise (hs_rise)
   );

   sync_edge_det u_vs_det (
      .clk  (pix_clk),
      .rst  (pix_rst),
      .sig  (vsync_i),
      .rise (vs_rise)
   );

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             vs_pending;
   logic             line_act;
   logic             pix_act;
   logic             lock_ok;

   assign line_act = (v_cnt >= V_START) && (v_cnt < V_END);
   assign pix_act  = (h_cnt >= H_START) && (h_cnt < H_END);

`ifdef TIMING_GEN_LOCK_EN
   localparam logic [CNT_W-1:0] V_TOTAL_L = CNT_W'(V_TOTAL);

   logic [CNT_W-1:0] frame_lines;
   logic             vs_seen;
   logic             lock;

   // An hsync rise coinciding with vsync rise belongs to the new frame.
   always_ff @(posedge pix_clk or posedge pix_rst) begin
      if (pix_rst) begin
         frame_lines <= '0;
         vs_seen     <= 1'b0;
         lock        <= 1'b0;
      end else if (vs_rise) begin
         lock        <= vs_seen && (frame_lines == V_TOTAL_L);
         vs_seen     <= 1'b1;
         frame_lines <= hs_rise ? CNT_W'(1) : '0;
      end else if (hs_rise) begin
         if (frame_lines == V_TOTAL_L) begin
            lock <= 1'b0;
         end
         frame_lines <= sat_inc(frame_lines);
      end
   end

   assign lock_ok = lock;
`else
   assign lock_ok = 1'b1;
`endif

   always_ff @(posedge pix_clk or posedge pix_rst) begin
      if (pix_rst) begin
         h_cnt      <= CNT_SAT;
         v_cnt      <= CNT_SAT;
         vs_pending <= 1'b0;
         fv_o       <= 1'b0;
         lv_o       <= 1'b0;
      end else begin
         h_cnt <= hs_rise ? '0 : sat_inc(h_cnt);
         if (hs_rise) begin
            vs_pending <= 1'b0;
            v_cnt      <= (vs_pending || vs_rise) ? '0 : sat_inc(v_cnt);
         end else if (vs_rise) begin
            vs_pending <= 1'b1;
         end
         fv_o <= line_act && lock_ok;
         lv_o <= line_act && pix_act && lock_ok;
      end
   end

endmodule

// File: tb/tb_timing_gen.sv
module tb_timing_gen;

   localparam int HA  = 16;
   localparam int HS  = 4;
   localparam int HBP = 6;
   localparam int HFP = 3;
   localparam int VA  = 6;
   localparam int VS  = 2;
   localparam int VBP = 3;
   localparam int VFP = 2;
   localparam int LINE  = HS + HBP + HA + HFP;   // 29 cycles
   localparam int FRAME = VS + VBP + VA + VFP;   // 13 lines

   logic pix_clk = 1'b0;
   logic pix_rst;
   logic vsync_i;
   logic hsync_i;
   logic fv_o;
   logic lv_o;

   timing_gen #(
      .H_ACTIVE      (HA),
      .H_SYNC        (HS),
      .H_BACK_PORCH  (HBP),
      .H_FRONT_PORCH (HFP),
      .V_ACTIVE      (VA),
      .V_SYNC        (VS),
      .V_BACK_PORCH  (VBP),
      .V_FRONT_PORCH (VFP)
   ) dut (
      .pix_clk (pix_clk),
      .pix_rst (pix_rst),
      .vsync_i (vsync_i),
      .hsync_i (hsync_i),
      .fv_o    (fv_o),
      .lv_o    (lv_o)
   );

   always #5 pix_clk = ~pix_clk;

   int n_checks = 0;
   int n_fail   = 0;

   int mism_fv, mism_lv, lv_cnt, fv_cnt, lv_first;
   int cur_line  = -1;
   int prev_line = -1;
   int prev_len  = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit act_line(input int l);
      return (l >= VS + VBP) && (l < VS + VBP + VA);
   endfunction

   function automatic bit act_pix(input int h);
      return (h >= HS + HBP) && (h < HS + HBP + HA);
   endfunction

   task automatic clear_stats();
      mism_fv  = 0;
      mism_lv  = 0;
      lv_cnt   = 0;
      fv_cnt   = 0;
      lv_first = -1;
   endtask

   // One pixel period: drive at negedge, sample 1 time unit after posedge.
   // Sample j of a line follows the edge that sees the hsync rise when j==0,
   // so outputs at j reflect the pixel position j-1 (or the previous line's
   // last pixel when j==0).
   task automatic tick(input bit hs, input bit vs, input int j);
      bit e_lv, e_fv;
      @(negedge pix_clk);
      hsync_i = hs;
      vsync_i = vs;
      @(posedge pix_clk);
      #1;
      if (j == 0) begin
         e_fv = act_line(prev_line);
         e_lv = act_line(prev_line) && act_pix(prev_len - 1);
      end else begin
         e_fv = act_line(cur_line);
         e_lv = act_line(cur_line) && act_pix(j - 1);
      end
      if (lv_o !== e_lv) mism_lv++;
      if (fv_o !== e_fv) mism_fv++;
      if (lv_o === 1'b1) lv_cnt++;
      if (fv_o === 1'b1) fv_cnt++;
      if (lv_o === 1'b1 && lv_first < 0 && j > 0) lv_first = j;
   endtask

   task automatic run_line(input int len, input bit vs_hi, input int line_no);
      prev_line = cur_line;
      cur_line  = line_no;
      for (int j = 0; j < len; j++) tick(j < HS, vs_hi, j);
      prev_len = len;
   endtask

   task automatic run_frame(input int short_line, input int short_len);
      clear_stats();
      for (int l = 0; l < FRAME; l++)
         run_line((l == short_line) ? short_len : LINE, l < VS, l);
   endtask

   initial begin
      pix_rst = 1'b1;
      vsync_i = 1'b0;
      hsync_i = 1'b0;
      repeat (3) @(posedge pix_clk);
      #1;
      check_val("rst_fv", fv_o, 0);
      check_val("rst_lv", lv_o, 0);
      @(negedge pix_clk);
      pix_rst = 1'b0;

      // Idle after reset with syncs low.
      clear_stats();
      for (int i = 0; i < 2000; i++) tick(1'b0, 1'b0, 1);
      check_val("idle_fv_cnt", fv_cnt, 0);
      check_val("idle_lv_cnt", lv_cnt, 0);

      // Lines without any vsync: counters stay saturated.
      clear_stats();
      for (int i = 0; i < 3; i++) run_line(LINE, 1'b0, -1);
      check_val("nosync_fv_cnt", fv_cnt, 0);
      check_val("nosync_lv_cnt", lv_cnt, 0);

      // Three standard frames.
      for (int f = 0; f < 3; f++) begin
         run_frame(-1, 0);
         check_val($sformatf("frame%0d_lv_cnt", f), lv_cnt, VA * HA);
         check_val($sformatf("frame%0d_fv_cnt", f), fv_cnt, VA * LINE);
         check_val($sformatf("frame%0d_lv_first", f), lv_first, HS + HBP + 1);
         check_val($sformatf("frame%0d_lv_mism", f), mism_lv, 0);
         check_val($sformatf("frame%0d_fv_mism", f), mism_fv, 0);
      end

      // Frame with active line 7 cut to 20 cycles.
      run_frame(7, 20);
      check_val("short_lv_cnt", lv_cnt, (VA - 1) * HA + 10);
      check_val("short_fv_cnt", fv_cnt, VA * LINE - (LINE - 20));
      check_val("short_lv_mism", mism_lv, 0);
      check_val("short_fv_mism", mism_fv, 0);

      // Reset in the middle of active line 7 while lv_o is high.
      clear_stats();
      for (int l = 0; l < 7; l++) run_line(LINE, l < VS, l);
      prev_line = cur_line;
      cur_line  = 7;
      for (int j = 0; j < 16; j++) tick(j < HS, 1'b0, j);
      check_val("partial_lv_mism", mism_lv, 0);
      check_val("pre_rst_lv", lv_o, 1);
      check_val("pre_rst_fv", fv_o, 1);
      #1;
      pix_rst = 1'b1;
      #1;
      check_val("midrst_fv", fv_o, 0);
      check_val("midrst_lv", lv_o, 0);
      repeat (2) @(negedge pix_clk);
      pix_rst   = 1'b0;
      cur_line  = -1;
      prev_line = -1;
      prev_len  = LINE;
      clear_stats();
      for (int i = 0; i < 4; i++) run_line(LINE, 1'b0, -1);
      check_val("postrst_fv_cnt", fv_cnt, 0);
      check_val("postrst_lv_cnt", lv_cnt, 0);

      run_frame(-1, 0);
      check_val("resume_lv_cnt", lv_cnt, VA * HA);
      check_val("resume_lv_mism", mism_lv, 0);
      check_val("resume_fv_mism", mism_fv, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/timing_gen.md
TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 SHALL have parameters H_ACTIVE (1280, active pixels/line), H_SYNC (40, hsync width), H_BACK_PORCH (220), H_FRONT_PORCH (110), all in pix_clk cycles.
REQ-002 SHALL have parameters V_ACTIVE (720, active lines/frame), V_SYNC (5), V_BACK_PORCH (20), V_FRONT_PORCH (5), all in lines.
REQ-003 pix_clk  in  1  pixel clock; all logic on its rising edge.
REQ-004 pix_rst  in  1  reset, asynchronous, active-high.
REQ-005 vsync_i  in  1  vertical sync, active-high, synchronous to pix_clk.
REQ-006 hsync_i  in  1  horizontal sync, active-high, synchronous to pix_clk.
REQ-007 fv_o  out  1  frame valid, registered.
REQ-008 lv_o  out  1  line valid, registered.

Function
REQ-009 SHALL register hsync_i and vsync_i once (hs_q, vs_q); hsync rise = hsync_i & ~hs_q, vsync rise = vsync_i & ~vs_q.
REQ-010 SHALL keep 16-bit h_cnt: 0 on the edge where hsync rise is detected, else +1, saturating at 16'hFFFF.
REQ-011 SHALL keep a vs_pending flag, set on vsync rise and cleared on the next hsync rise; vsync rise and hsync rise in the same cycle count as pending for that line.
REQ-012 SHALL keep 16-bit v_cnt updated only on hsync rise: 0 if vs_pending (or vsync rise this cycle), else +1, saturating at 16'hFFFF.
REQ-013 Active line: V_SYNC+V_BACK_PORCH <= v_cnt < V_SYNC+V_BACK_PORCH+V_ACTIVE; active pixel: H_SYNC+H_BACK_PORCH <= h_cnt < H_SYNC+H_BACK_PORCH+H_ACTIVE.
REQ-014 lv_o SHALL be registered (active line AND active pixel) of current counters: exactly H_ACTIVE cycles high, first rising edge H_SYNC+H_BACK_PORCH+1 cycles after the edge detecting hsync rise.
REQ-015 fv_o SHALL be registered (active line); it rises one cycle after the first active line's hsync rise and falls one cycle after the hsync rise following the last active line.
REQ-016 Front-porch parameters SHALL not gate outputs; lines/pixels beyond the active window simply stay inactive until the next sync.
REQ-017 Short lines (hsync before window ends) SHALL truncate lv_o at the new hsync rise + 1 cycle; short frames SHALL restart v_cnt at the next vsync.
REQ-018 Before the first vsync rise after reset, v_cnt is saturated, so fv_o/lv_o SHALL remain 0.
REQ-019 Held-high syncs SHALL generate only one event per rising edge.

Reset
REQ-020 pix_rst SHALL asynchronously clear hs_q, vs_q, vs_pending, fv_o, lv_o to 0 and set h_cnt, v_cnt to 16'hFFFF.
REQ-021 Reset mid-frame SHALL drop fv_o/lv_o immediately; generation resumes only after a new vsync rise.

Configuration
REQ-022 Macro TIMING_GEN_LOCK_EN: when defined, outputs SHALL be gated by a lock flag set after two consecutive vsync rises exactly V_SYNC+V_BACK_PORCH+V_ACTIVE+V_FRONT_PORCH hsync rises apart, cleared on any mismatch or reset.
REQ-023 Without TIMING_GEN_LOCK_EN, outputs SHALL follow REQ-014/015 from the first vsync rise, with no lock logic.

Structure
REQ-024 Package timing_gen_pkg SHALL hold counter width (16) and saturate constant; window bounds are derived localparams in timing_gen.
REQ-025 One sub-module sync_edge_det (register + rise detect) SHALL be instantiated for each of hsync_i and vsync_i.

Verification (defaults, 720p: 1650 cycles/line, 750 lines/frame)
REQ-026 Reset, then hold syncs low 2000 cycles -> fv_o=lv_o=0 throughout.
REQ-027 Standard frame (vsync high 5 lines, hsync high 40 cycles/line) -> lv_o rises 261 cycles after hsync-rise edge, 1280 cycles wide, on exactly 720 lines/frame (lines 25..744).
REQ-028 Same -> fv_o rises 1 cycle after line 25's hsync rise, falls 1 cycle after line 745's hsync rise; 3 consecutive frames identical.
REQ-029 Assert pix_rst mid-line 100 -> outputs 0 same instant; no output until the next vsync rise.
REQ-030 Line shortened to 1000 cycles -> lv_o ends 1 cycle after the early hsync rise; next line normal.
REQ-031 TIMING_GEN_LOCK_EN: first frame silent, second frame outputs; a 749-line frame -> lock lost, outputs 0 until two good vsyncs.
